// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch sequencer: holds committed NZCV flags, resolves jumps,
// issues a fetch redirect over valid/ready, then flushes IF/ID for a fixed window.
module branch_resolve_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_STAGES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic [3:0]        ex_alu_flags,
  input  logic              ex_jump,
  input  logic              ex_jump_cond,
  input  logic [2:0]        ex_jump_cond_type,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              stall,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int unsigned FC_W = 4;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            ge, gt, cond_true, taken, is_branch, idle;

  // Conditions use only the committed flags {N,Z,C,V}
  assign ge = (flags_q[3] == flags_q[0]);
  assign gt = ~flags_q[2] & ge;

  always_comb begin
    cond_true = 1'b0;
    case (ex_jump_cond_type)
      3'd0:    cond_true = flags_q[2];
      3'd1:    cond_true = ~flags_q[2];
      3'd2:    cond_true = gt;
      3'd3:    cond_true = ~ge;
      3'd4:    cond_true = ge;
      3'd5:    cond_true = ~gt;
      default: cond_true = 1'b0;
    endcase
  end

  assign idle      = (state_q == IDLE);
  assign is_branch = ex_valid & (ex_jump | ex_jump_cond);
  assign taken     = ex_valid & (ex_jump | (ex_jump_cond & cond_true));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    case (state_q)
      IDLE: begin
        if (taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        if (redirect_ready) begin
          fcnt_d  = FC_W'(FLUSH_STAGES - 1);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_if_id = 1'b1;
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags, redirect target and saturating counters only move in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
    end else if (idle) begin
      if (ex_valid && ex_set_flags) flags_q <= ex_alu_flags;
      if (taken) redirect_pc <= ex_target;
      if (is_branch && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_branch_resolve_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned FS     = 2;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ex_valid = 1'b0, ex_set_flags = 1'b0, ex_jump = 1'b0, ex_jump_cond = 1'b0;
  logic [3:0]        ex_alu_flags = '0;
  logic [2:0]        ex_jump_cond_type = '0;
  logic [ADDR_W-1:0] ex_target = '0;
  logic              redirect_ready = 1'b0;
  logic              redirect_valid, flush_if_id, flush_id_ex, stall;
  logic [ADDR_W-1:0] redirect_pc;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  branch_cnt, taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve_ctrl #(.ADDR_W(ADDR_W), .FLUSH_STAGES(FS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_alu_flags(ex_alu_flags),
    .ex_jump(ex_jump), .ex_jump_cond(ex_jump_cond), .ex_jump_cond_type(ex_jump_cond_type),
    .ex_target(ex_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall(stall),
    .flags_q(flags_q), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] f, input logic [2:0] t);
    bit z, lt;
    z  = f[2];
    lt = (f[3] != f[0]);
    case (t)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !z && !lt;
      3'd3: return lt;
      3'd4: return !lt;
      3'd5: return z || lt;
      default: return 1'b0;
    endcase
  endfunction

  // Model: a pending redirect, a number of flush cycles left, and registered values
  bit          m_redir;
  int          m_flush_left;
  logic [3:0]  m_flags;
  logic [31:0] m_pc;
  int          m_bc, m_tc;

  function automatic bit m_taken();
    return (!m_redir && m_flush_left == 0) && ex_valid &&
           (ex_jump || (ex_jump_cond && cond_ok(m_flags, ex_jump_cond_type)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_redir = 0; m_flush_left = 0; m_flags = '0; m_pc = '0; m_bc = 0; m_tc = 0;
    end else if (!m_redir && m_flush_left == 0) begin
      if (m_taken()) begin
        m_tc    = (m_tc < 65535) ? m_tc + 1 : m_tc;
        m_pc    = ex_target;
        m_redir = 1;
      end
      if (ex_valid && (ex_jump || ex_jump_cond)) m_bc = (m_bc < 65535) ? m_bc + 1 : m_bc;
      if (ex_valid && ex_set_flags) m_flags = ex_alu_flags;
    end else if (m_redir) begin
      if (redirect_ready) begin
        m_redir      = 0;
        m_flush_left = FS;
      end
    end else begin
      m_flush_left--;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    bit tk;
    tk = m_taken();
    chk("flush_if_id",    64'(flush_if_id),    64'(tk || m_flush_left > 0));
    chk("flush_id_ex",    64'(flush_id_ex),    64'(tk));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
    chk("stall",          64'(stall),          64'(m_redir));
    chk("redirect_pc",    64'(redirect_pc),    64'(m_pc));
    chk("flags_q",        64'(flags_q),        64'(m_flags));
    chk("branch_cnt",     64'(branch_cnt),     64'(m_bc));
    chk("taken_cnt",      64'(taken_cnt),      64'(m_tc));
  end

  task automatic set_in(input bit v, input bit sf, input logic [3:0] alu, input bit j,
                        input bit jc, input logic [2:0] ty, input logic [31:0] tgt, input bit rdy);
    ex_valid = v; ex_set_flags = sf; ex_alu_flags = alu; ex_jump = j;
    ex_jump_cond = jc; ex_jump_cond_type = ty; ex_target = tgt; redirect_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_in(0, 0, 4'h0, 0, 0, 3'd0, 32'h0, 1);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    set_in(0, 0, 4'h0, 0, 0, 3'd0, 32'h0, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  // One conditional branch followed by enough idle cycles to drain
  task automatic cbranch(input logic [2:0] ty, input bit exp_taken, input string name);
    set_in(1, 0, 4'h0, 0, 1, ty, 32'h1000, 1);
    @(negedge clk);
    chk(name, 64'(flush_id_ex), 64'(exp_taken));
    tick();
    idle_cycles(4);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_flags", 64'(flags_q), 64'h0);
    chk("reset_rv",    64'(redirect_valid), 64'h0);
    chk("reset_cnt",   64'(branch_cnt), 64'h0);
    #2 rst = 1'b0;
    tick();

    // Flag write then EQ branch
    set_in(1, 1, 4'b0100, 0, 0, 3'd0, 32'h0, 1); tick();
    set_in(1, 0, 4'h0, 0, 1, 3'd0, 32'h40, 1);
    @(negedge clk);
    chk("t1_flush_if_id", 64'(flush_if_id), 64'h1);
    chk("t1_flush_id_ex", 64'(flush_id_ex), 64'h1);
    tick();
    set_in(0, 0, 4'h0, 0, 0, 3'd0, 32'h0, 1);
    @(negedge clk);
    chk("t1_rv",    64'(redirect_valid), 64'h1);
    chk("t1_pc",    64'(redirect_pc), 64'h40);
    chk("t1_stall", 64'(stall), 64'h1);
    tick(); @(negedge clk);
    chk("t1_flush_c3", 64'(flush_if_id), 64'h1);
    tick(); @(negedge clk);
    chk("t1_flush_c4", 64'(flush_if_id), 64'h1);
    tick(); @(negedge clk);
    chk("t1_idle_flush", 64'(flush_if_id), 64'h0);
    chk("t1_taken_cnt",  64'(taken_cnt), 64'h1);
    tick();

    // Signed conditions
    do_reset();
    set_in(1, 1, 4'b1000, 0, 0, 3'd0, 32'h0, 1); tick();
    cbranch(3'd3, 1, "lt_n1v0");
    cbranch(3'd4, 0, "ge_n1v0");
    cbranch(3'd5, 1, "le_n1v0");
    set_in(1, 1, 4'b0000, 0, 0, 3'd0, 32'h0, 1); tick();
    cbranch(3'd2, 1, "gt_zero");
    cbranch(3'd5, 0, "le_zero");
    cbranch(3'd6, 0, "code6");
    chk("six_branch_cnt", 64'(branch_cnt), 64'd6);
    chk("six_taken_cnt",  64'(taken_cnt), 64'd3);
    cbranch(3'd7, 0, "code7");

    // Set flags and jump in one instruction: resolves on old flags
    do_reset();
    set_in(1, 1, 4'b0100, 0, 1, 3'd1, 32'h80, 1);
    @(negedge clk);
    chk("setjump_taken", 64'(flush_id_ex), 64'h1);
    tick();
    chk("setjump_flags", 64'(flags_q), 64'h4);
    idle_cycles(4);

    // Backpressure with ignored ex_* activity
    set_in(1, 0, 4'h0, 1, 0, 3'd0, 32'hABCD0000, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 4'b1011, 1, 1, 3'd0, 32'h1234, 0);
      @(negedge clk);
      chk("bp_rv",    64'(redirect_valid), 64'h1);
      chk("bp_stall", 64'(stall), 64'h1);
      chk("bp_pc",    64'(redirect_pc), 64'hABCD0000);
      chk("bp_flags", 64'(flags_q), 64'h4);
      chk("bp_bcnt",  64'(branch_cnt), 64'd2);
      chk("bp_tcnt",  64'(taken_cnt), 64'd2);
      tick();
    end
    idle_cycles(4);

    // Async reset mid-FLUSH
    set_in(1, 0, 4'h0, 1, 0, 3'd0, 32'h100, 1); tick();
    idle_cycles(1);
    #2 rst = 1'b1;
    #1;
    chk("rst_flush_if_id", 64'(flush_if_id), 64'h0);
    chk("rst_rv",          64'(redirect_valid), 64'h0);
    chk("rst_stall",       64'(stall), 64'h0);
    chk("rst_pc",          64'(redirect_pc), 64'h0);
    chk("rst_bcnt",        64'(branch_cnt), 64'h0);
    chk("rst_tcnt",        64'(taken_cnt), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    set_in(1, 0, 4'h0, 1, 0, 3'd0, 32'h200, 1);
    @(negedge clk);
    chk("post_rst_taken", 64'(flush_id_ex), 64'h1);
    tick();
    @(negedge clk);
    chk("post_rst_pc", 64'(redirect_pc), 64'h200);
    tick();
    idle_cycles(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 3'($urandom),
             32'($urandom), $urandom_range(0, 2) != 0);
      tick();
    end

    // Counter saturation
    do_reset();
    set_in(1, 0, 4'h0, 0, 1, 3'd6, 32'h0, 1);
    repeat (65535) tick();
    chk("sat_bcnt", 64'(branch_cnt), 64'hFFFF);
    chk("sat_tcnt", 64'(taken_cnt), 64'h0);
    tick();
    chk("sat_hold", 64'(branch_cnt), 64'hFFFF);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
